// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the restoring-division controller and datapath
package div_pkg;

   localparam int NBITS_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      SUB,
      RESOLVE,
      DONE
   } state_t;

   localparam logic [1:0] SEL_PASS = 2'b00;
   localparam logic [1:0] SEL_SUB  = 2'b01;
   localparam logic [1:0] SEL_ADD  = 2'b10;
   localparam logic [1:0] SEL_QBIT = 2'b11;

endpackage

// File: rtl/div_controller.sv
// rtl/div_controller.sv - control FSM sequencing shift/subtract/resolve per quotient bit
module div_controller
   import div_pkg::*;
#(
   parameter int NBITS = NBITS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       divisor_zero,
   input  logic       sign,
   output logic       load,
   output logic       add,
   output logic       shift,
   output logic       inbit,
   output logic [1:0] sel,
   output logic       busy,
   output logic       done,
   output logic       dz_err
);

   localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

   state_t        state;
   logic [CW-1:0] count;
   logic          dz_flag;
   logic          in_resolve;
   logic [1:0]    sel_q;

   // Outputs are registered from the next state, so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         dz_flag    <= 1'b0;
         load       <= 1'b0;
         shift      <= 1'b0;
         add        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dz_err     <= 1'b0;
         sel_q      <= SEL_PASS;
         in_resolve <= 1'b0;
      end else begin
         load       <= 1'b0;
         shift      <= 1'b0;
         add        <= 1'b0;
         done       <= 1'b0;
         dz_err     <= 1'b0;
         sel_q      <= SEL_PASS;
         in_resolve <= 1'b0;
         busy       <= 1'b1;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  state   <= LOAD;
                  dz_flag <= divisor_zero;
                  load    <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            LOAD: begin
               if (dz_flag) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  dz_err <= 1'b1;
               end else begin
                  state <= SHIFT;
                  count <= '0;
                  shift <= 1'b1;
               end
            end
            SHIFT: begin
               state <= SUB;
               add   <= 1'b1;
               sel_q <= SEL_SUB;
            end
            SUB: begin
               state      <= RESOLVE;
               add        <= 1'b1;
               in_resolve <= 1'b1;
            end
            RESOLVE: begin
               if (count == LAST) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  dz_err <= dz_flag;
               end else begin
                  state <= SHIFT;
                  count <= count + 1'b1;
                  shift <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // The borrow of the subtract only exists in RESOLVE, so sel/inbit follow sign combinationally there.
   assign sel   = in_resolve ? (sign ? SEL_ADD : SEL_QBIT) : sel_q;
   assign inbit = in_resolve & ~sign;

endmodule

// File: tb/tb_div_controller.sv
// tb/tb_div_controller.sv - randomized bench with behavioural datapath and expected-trace model
module tb_div_controller;
   import div_pkg::*;

   logic       clk = 1'b0;
   logic       reset, start, divisor_zero, sign;
   logic       load, add, shift, inbit, busy, done, dz_err;
   logic [1:0] sel;

   div_controller #(.NBITS(8)) dut (
      .clk(clk), .reset(reset), .start(start), .divisor_zero(divisor_zero), .sign(sign),
      .load(load), .add(add), .shift(shift), .inbit(inbit), .sel(sel),
      .busy(busy), .done(done), .dz_err(dz_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       load, shift, add, inbit;
      logic [1:0] sel;
      logic       busy, done, dz_err;
   } ovec_t;

   typedef struct {
      ovec_t o;
      int    q;
      int    r;
      logic  check;
   } step_t;

   step_t exp_q[$];
   int    n_cmp = 0, n_bad = 0;
   int    a_in = 0, b_in = 0;
   logic  armed = 1'b0;
   int    cyc = 0, start_cyc = 0;
   int    n_done = 0, last_lat = 0, last_q = 0, last_r = 0, last_done_cyc = 0;
   logic  last_dz = 1'b0;
   int    n_shift = 0, n_add = 0, n_qbit = 0, n_addsel = 0;

   // Behavioural datapath with unbounded remainder arithmetic.
   int   dp_r = 0, dp_q = 0, dp_d = 0;
   logic dp_sign = 1'b0;
   always @(posedge clk) begin
      if (reset) begin
         dp_r <= 0; dp_q <= 0; dp_d <= 0; dp_sign <= 1'b0;
      end else if (load) begin
         dp_r <= 0; dp_q <= a_in; dp_d <= b_in;
      end else if (shift) begin
         dp_r <= dp_r * 2 + ((dp_q >> 7) & 1);
         dp_q <= ((dp_q << 1) & 255) | int'(inbit);
      end else if (add) begin
         case (sel)
            SEL_SUB:  begin dp_r <= dp_r - dp_d; dp_sign <= (dp_r < dp_d); end
            SEL_ADD:  dp_r <= dp_r + dp_d;
            SEL_QBIT: dp_q <= (dp_q & ~1) | int'(inbit);
            default:  ;
         endcase
      end
   end
   assign sign = dp_sign;

   function automatic ovec_t mk(logic l, logic s, logic a, logic ib, logic [1:0] sl,
                                logic dn, logic dz);
      ovec_t o;
      o.load = l; o.shift = s; o.add = a; o.inbit = ib; o.sel = sl;
      o.busy = 1'b1; o.done = dn; o.dz_err = dz;
      return o;
   endfunction

   // Expected trace derived from the quotient bits alone.
   task automatic build(int a, int b, logic dz);
      int q, r, bitv;
      q = dz ? 0 : a / b;
      r = dz ? 0 : a % b;
      exp_q.push_back('{mk(1, 0, 0, 0, SEL_PASS, 0, 0), 0, 0, 1'b0});
      if (dz) begin
         exp_q.push_back('{mk(0, 0, 0, 0, SEL_PASS, 1, 1), 0, 0, 1'b0});
         return;
      end
      for (int i = 0; i < 8; i++) begin
         bitv = (q >> (7 - i)) & 1;
         exp_q.push_back('{mk(0, 1, 0, 0, SEL_PASS, 0, 0), 0, 0, 1'b0});
         exp_q.push_back('{mk(0, 0, 1, 0, SEL_SUB, 0, 0), 0, 0, 1'b0});
         exp_q.push_back('{mk(0, 0, 1, bitv[0], bitv[0] ? SEL_QBIT : SEL_ADD, 0, 0), 0, 0, 1'b0});
      end
      exp_q.push_back('{mk(0, 0, 0, 0, SEL_PASS, 1, 0), q, r, 1'b1});
   endtask

   always @(posedge clk) begin
      if (reset) exp_q.delete();
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
      else if (start) begin
         start_cyc = cyc;
         build(a_in, b_in, divisor_zero);
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (armed) begin : cmp
         ovec_t got, want;
         got  = {load, shift, add, inbit, sel, busy, done, dz_err};
         want = (exp_q.size() > 0) ? exp_q[0].o : '0;
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL outputs cycle %0d: actual l/s/a/i/sel/b/d/z=%b required %b", cyc, got, want);
         end
         n_cmp++;
         if ($countones({load, shift, add}) > 1) begin
            n_bad++;
            $display("FAIL onehot cycle %0d: actual load/shift/add=%b required at most one high", cyc, {load, shift, add});
         end
         if (exp_q.size() > 0 && exp_q[0].check) begin
            n_cmp++;
            if (dp_q != exp_q[0].q || dp_r != exp_q[0].r) begin
               n_bad++;
               $display("FAIL qr cycle %0d: actual Q=%0d R=%0d required Q=%0d R=%0d",
                        cyc, dp_q, dp_r, exp_q[0].q, exp_q[0].r);
            end
         end
         if (done) begin
            n_done++;
            last_lat = cyc - start_cyc;
            last_dz = dz_err;
            last_q = dp_q;
            last_r = dp_r;
            last_done_cyc = cyc;
         end
         if (shift) n_shift++;
         if (add) n_add++;
         if (add && sel == SEL_QBIT && inbit) n_qbit++;
         if (add && sel == SEL_ADD) n_addsel++;
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(string name, int got, int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d", name, got, want);
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((exp_q.size() > 0 || busy) && k < 100) begin
         tick(1);
         k++;
      end
      if (k >= 100) chk("idle_timeout", k, 0);
   endtask

   task automatic clear_stats();
      n_shift = 0; n_add = 0; n_qbit = 0; n_addsel = 0;
   endtask

   task automatic set_ops(int a, int b);
      a_in = a;
      b_in = b;
      divisor_zero = (b == 0);
   endtask

   task automatic run_div(int a, int b);
      set_ops(a, b);
      clear_stats();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_idle();
   endtask

   initial begin
      int base, k, first_done;
      reset = 1'b1; start = 1'b0; divisor_zero = 1'b0;
      @(posedge clk);
      #1;
      armed = 1'b1;
      tick(2);
      chk("reset_busy", int'(busy), 0);
      chk("reset_outs", int'({load, shift, add, done, dz_err}), 0);
      reset = 1'b0;
      tick(2);

      run_div(200, 7);
      chk("200/7 latency", last_lat, 26);
      chk("200/7 Q", last_q, 28);
      chk("200/7 R", last_r, 4);
      chk("200/7 dz_err", int'(last_dz), 0);
      chk("200/7 shifts", n_shift, 8);

      run_div(255, 1);
      chk("255/1 Q", last_q, 255);
      chk("255/1 R", last_r, 0);
      chk("255/1 qbit resolves", n_qbit, 8);
      chk("255/1 add resolves", n_addsel, 0);

      run_div(5, 100);
      chk("5/100 Q", last_q, 0);
      chk("5/100 R", last_r, 5);
      chk("5/100 add resolves", n_addsel, 8);

      run_div(77, 0);
      chk("dz latency", last_lat, 2);
      chk("dz dz_err", int'(last_dz), 1);
      chk("dz shifts", n_shift, 0);
      chk("dz adds", n_add, 0);

      // Reset arrives in cycle 10 of a division and is held for 3 cycles.
      set_ops(200, 7);
      base = n_done;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(9);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("midreset no done", n_done, base);
      chk("midreset busy", int'(busy), 0);
      run_div(100, 9);
      chk("after reset Q", last_q, 11);
      chk("after reset R", last_r, 1);

      // Start pulses while busy must be ignored.
      set_ops(150, 11);
      base = n_done;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(3);
         start = 1'b1;
         tick(1);
         start = 1'b0;
      end
      wait_idle();
      chk("busy pulses dones", n_done - base, 1);
      chk("busy pulses Q", last_q, 13);

      // Start held high: back-to-back divisions with one IDLE cycle between them.
      set_ops(90, 13);
      base = n_done;
      first_done = 0;
      start = 1'b1;
      k = 0;
      while (n_done - base < 2 && k < 200) begin
         tick(1);
         if (n_done - base == 1 && first_done == 0) first_done = last_done_cyc;
         k++;
      end
      start = 1'b0;
      chk("held start dones", n_done - base, 2);
      chk("held start gap", last_done_cyc - first_done, 27);
      wait_idle();

      for (int i = 0; i < 10; i++) begin
         int a, b;
         a = int'($urandom_range(0, 255));
         b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 127));
         tick(int'($urandom_range(0, 3)));
         run_div(a, b);
      end

      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
